// File: rtl/ifu32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ifu32                                                           |
// | Brief    : RV32 instruction fetch unit. Owns the PC, issues one word fetch |
// |            at a time over a valid/ready request channel, registers the     |
// |            returned word with its PC and pre-split decode fields, and      |
// |            hands it downstream over a valid/ready channel. Redirects from  |
// |            execute replace the PC and cause any in-flight fetch to be      |
// |            discarded when it returns.                                      |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module ifu32 #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,

   // instruction memory request channel
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,

   // instruction memory response channel (no backpressure)
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,

   // PC redirect from execute
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,

   // decoder-facing instruction channel
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [6:0]  opcode,
   output logic [3:0]  funct3,
   output logic [7:0]  funct7
);

   // IDLE : one cycle after reset before the first request
   // REQ  : request presented to memory, waiting for ready
   // WAIT : request accepted, waiting for the response
   // HOLD : instruction presented to the decoder, waiting for ready
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        drop_q, drop_d;

   // Redirect target is always word aligned; low two bits are discarded.
   logic [31:0] redirect_tgt;
   assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

   // Next-state and datapath updates; redirect overrides the PC last so it
   // wins over the sequential pc+4 advance taken on a captured response.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      drop_d    = drop_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end

         S_REQ: begin
            if (imem_req_ready) begin
               state_d = S_WAIT;
               // A redirect coinciding with acceptance makes this fetch stale.
               drop_d  = redirect_valid;
            end
         end

         S_WAIT: begin
            if (imem_resp_valid) begin
               // Any response leaves WAIT; only a fresh, non-redirected
               // one is captured and handed downstream.
               state_d = S_REQ;
               drop_d  = 1'b0;
               if (!drop_q && !redirect_valid) begin
                  inst_d    = imem_resp_data;
                  inst_pc_d = pc_q;
                  pc_d      = pc_q + 32'd4;
                  state_d   = S_HOLD;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end
         end

         S_HOLD: begin
            // Consumption and redirect both release the held instruction.
            if (inst_ready || redirect_valid) begin
               state_d = S_REQ;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (redirect_valid) begin
         pc_d = redirect_tgt;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         drop_q    <= 1'b0;
         inst_q    <= 32'd0;
         inst_pc_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         drop_q    <= drop_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   // Handshake valids are pure functions of state; no input feeds an output.
   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = pc_q;
   assign inst_valid     = (state_q == S_HOLD);

   assign inst    = inst_q;
   assign inst_pc = inst_pc_q;

   // Decode fields are plain slices of the registered instruction word.
   assign opcode = inst_q[6:0];
   assign funct3 = {1'b0, inst_q[14:12]};
   assign funct7 = {1'b0, inst_q[31:25]};

endmodule
`default_nettype wire

// File: tb/tb_ifu32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ifu32                                                        |
// | Brief    : Self-checking bench for ifu32: transaction-level reference      |
// |            model, memory responder, directed scenarios and random run.     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_ifu32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic [6:0]  opcode;
   logic [3:0]  funct3;
   logic [7:0]  funct7;

   always #5 clk = ~clk;

   ifu32 #(.RESET_PC(32'h8000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc),
      .opcode(opcode), .funct3(funct3), .funct7(funct7)
   );

   int vectors = 0;
   int errs    = 0;

   // Reference model: protocol bookkeeping, state as seen after the next edge.
   bit          m_alive, m_out, m_stale, m_has;
   logic [31:0] m_pc, m_inst, m_ipc;
   int          pend;
   logic [31:0] pend_data;
   logic [31:0] hs_q[$];

   // Stimulus knobs (percentages) and one-shot redirect override.
   int          k_rdy = 100, k_ird = 100, k_redir = 0, k_spur = 0;
   int          k_latmin = 1, k_latmax = 1;
   bit          k_fix_en = 1'b1;
   logic [31:0] k_fix = 32'h0000_0013;
   bit          f_redir = 1'b0;
   logic [31:0] f_redir_pc = 32'd0;
   logic        rst_next = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      errs++;
      $display("FAIL %s: got timeout, expected event", nm);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return k_fix_en ? k_fix : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      m_alive = 0; m_out = 0; m_stale = 0; m_has = 0;
      m_pc = 32'h8000_0000; m_inst = 32'd0; m_ipc = 32'd0;
   endtask

   // One clock: compare DUT against model, drive next inputs, advance model.
   task automatic step();
      bit          exp_req, rdy, ird, redir, rv;
      logic [31:0] rpc, rdata;
      @(negedge clk);
      exp_req = m_alive && !m_out && !m_has;
      chk("req_valid", imem_req_valid, exp_req);
      if (exp_req) chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", inst_valid, m_has);
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_ipc);
      if (m_has) begin
         chk("opcode", opcode, m_inst[6:0]);
         chk("funct3", funct3, {1'b0, m_inst[14:12]});
         chk("funct7", funct7, {1'b0, m_inst[31:25]});
      end

      rdy   = ($urandom % 100) < k_rdy;
      ird   = ($urandom % 100) < k_ird;
      redir = f_redir || (($urandom % 100) < k_redir);
      rpc   = f_redir ? f_redir_pc : $urandom;
      f_redir = 1'b0;
      rv    = 1'b0;
      rdata = $urandom;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            rv = 1'b1;
            rdata = pend_data;
         end
      end else if (($urandom % 100) < k_spur) begin
         rv = 1'b1;
      end

      rst_n           = rst_next;
      imem_req_ready  = rdy;
      inst_ready      = ird;
      redirect_valid  = redir;
      redirect_pc     = rpc;
      imem_resp_valid = rv;
      imem_resp_data  = rdata;
      vectors++;

      if (!rst_n) begin
         model_reset();
      end else begin
         if (!m_alive) begin
            m_alive = 1;
         end else if (exp_req) begin
            if (rdy) begin
               m_out = 1; m_stale = redir;
               hs_q.push_back(m_pc);
               pend = $urandom_range(k_latmax, k_latmin);
               pend_data = mem_word(m_pc);
            end
         end else if (m_out) begin
            if (rv) begin
               m_out = 0;
               if (!(m_stale || redir)) begin
                  m_has = 1; m_inst = rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
               end
               m_stale = 0;
            end else if (redir) begin
               m_stale = 1;
            end
         end else if (m_has) begin
            if (redir || ird) m_has = 0;
         end
         if (redir) m_pc = {rpc[31:2], 2'b00};
      end
   endtask

   int iv_cnt;

   initial begin
      rst_n = 1'b0; imem_req_ready = 0; inst_ready = 0; redirect_valid = 0;
      redirect_pc = 0; imem_resp_valid = 0; imem_resp_data = 0;
      pend = 0; pend_data = 0;
      model_reset();

      // Reset state and first fetches with zero-wait memory returning NOP.
      repeat (3) step();
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_inst_valid", inst_valid, 1'b0);
      rst_next = 1'b1;
      hs_q.delete();
      step();
      step();
      chk("first_req", imem_req_valid, 1'b1);
      chk("first_addr", imem_req_addr, 32'h8000_0000);
      step();
      step();
      chk("first_iv", inst_valid, 1'b1);
      chk("first_ipc", inst_pc, 32'h8000_0000);
      chk("nop_opcode", opcode, 7'h13);
      repeat (9) step();
      if (hs_q.size() >= 3) begin
         chk("seq0", hs_q[0], 32'h8000_0000);
         chk("seq1", hs_q[1], 32'h8000_0004);
         chk("seq2", hs_q[2], 32'h8000_0008);
      end else tmo("seq");

      // Backpressure on a SUB instruction.
      k_fix = 32'h40B5_0533;
      for (int n = 0; n < 20 && !(m_out && pend_data == 32'h40B5_0533); n++) step();
      k_ird = 0;
      for (int n = 0; n < 20 && !inst_valid; n++) step();
      if (!inst_valid) tmo("bp_wait");
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_req", imem_req_valid, 1'b0);
         chk("bp_iv", inst_valid, 1'b1);
         chk("bp_inst", inst, 32'h40B5_0533);
         chk("bp_f7", funct7, 8'h20);
         chk("bp_f3", funct3, 4'h0);
         chk("bp_op", opcode, 7'h33);
      end
      k_ird = 100;

      // Redirect in WAIT, stale response two cycles later.
      k_latmin = 3; k_latmax = 3;
      for (int n = 0; n < 20 && !(m_out && pend == 3); n++) step();
      f_redir = 1; f_redir_pc = 32'h8000_0102;
      hs_q.delete();
      iv_cnt = 0;
      for (int n = 0; n < 20 && hs_q.size() == 0; n++) begin
         step();
         if (inst_valid) iv_cnt++;
      end
      chk("wait_redir_iv", iv_cnt, 0);
      if (hs_q.size() > 0) chk("wait_redir_addr", hs_q[0], 32'h8000_0100);
      else tmo("wait_redir");
      k_latmin = 1; k_latmax = 1;

      // Redirect coincident with the REQ handshake.
      for (int n = 0; n < 20 && !(m_alive && !m_out && !m_has); n++) step();
      f_redir = 1; f_redir_pc = 32'h8000_0200;
      step();
      hs_q.delete();
      for (int n = 0; n < 20 && hs_q.size() == 0; n++) step();
      if (hs_q.size() > 0) chk("req_redir_addr", hs_q[0], 32'h8000_0200);
      else tmo("req_redir");
      for (int n = 0; n < 20 && !inst_valid; n++) step();
      chk("req_redir_ipc", inst_pc, 32'h8000_0200);

      // Redirect in HOLD coincident with consumption.
      for (int n = 0; n < 20 && !m_has; n++) step();
      f_redir = 1; f_redir_pc = 32'h8000_0300;
      hs_q.delete();
      step();
      step();
      chk("hold_redir_iv", inst_valid, 1'b0);
      for (int n = 0; n < 20 && hs_q.size() == 0; n++) step();
      if (hs_q.size() > 0) chk("hold_redir_addr", hs_q[0], 32'h8000_0300);
      else tmo("hold_redir");

      // PC wrap past the top of the address space.
      for (int n = 0; n < 20 && !m_has; n++) step();
      f_redir = 1; f_redir_pc = 32'hFFFF_FFFC;
      hs_q.delete();
      for (int n = 0; n < 30 && hs_q.size() < 2; n++) step();
      if (hs_q.size() >= 2) begin
         chk("wrap_a", hs_q[0], 32'hFFFF_FFFC);
         chk("wrap_b", hs_q[1], 32'h0000_0000);
      end else tmo("wrap");

      // Asynchronous reset in the middle of WAIT.
      k_latmin = 3; k_latmax = 3;
      for (int n = 0; n < 20 && !(m_out && pend == 3); n++) step();
      step();
      #2 rst_n = 1'b0;
      rst_next = 1'b0;
      model_reset();
      #1;
      chk("arst_req_valid", imem_req_valid, 1'b0);
      chk("arst_iv", inst_valid, 1'b0);
      chk("arst_inst", inst, 32'd0);
      chk("arst_ipc", inst_pc, 32'd0);
      repeat (3) step();
      rst_next = 1'b1;
      hs_q.delete();
      for (int n = 0; n < 20 && hs_q.size() == 0; n++) step();
      if (hs_q.size() > 0) chk("arst_restart", hs_q[0], 32'h8000_0000);
      else tmo("arst_restart");

      // Randomised traffic against the model.
      k_fix_en = 1'b0; k_rdy = 70; k_ird = 70; k_redir = 5; k_spur = 5;
      k_latmin = 1; k_latmax = 3;
      repeat (3000) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ifu32.md
# ifu32

Instruction fetch unit for the RV32 core; sits directly upstream of the instruction decoder. Keeps the program counter and issues one word fetch at a time to instruction memory over a valid/ready request channel. Registers the returned word with its PC and pre-split decode fields (opcode, funct3, funct7), then hands it downstream over a valid/ready channel. Accepts PC redirects from the execute stage and discards stale fetches.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  word address of the fetch; equals the current PC.
- `imem_resp_valid`  in  1  read data valid; no backpressure.
- `imem_resp_data`  in  32  fetched instruction word.
- `redirect_valid`  in  1  one-cycle pulse to change the PC.
- `redirect_pc`  in  32  new PC; bits [1:0] are forced to 0 internally.
- `inst_valid`  out  1  instruction available to the decoder.
- `inst_ready`  in  1  decoder consumes the instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  PC of `inst`.
- `opcode`  out  7  `inst[6:0]`.
- `funct3`  out  4  `{1'b0, inst[14:12]}`.
- `funct7`  out  8  `{1'b0, inst[31:25]}`.

## Operation
- States: IDLE, REQ, WAIT, HOLD. One request outstanding at most.
- IDLE: entered only by reset; moves to REQ on the next clock, unconditionally.
- REQ: `imem_req_valid`=1 and `imem_req_addr`=pc.
  - Handshake (valid & ready) moves to WAIT.
  - Address is held stable until the handshake, except on redirect.
- WAIT: waits for `imem_resp_valid`.
  - If `drop`=0: capture `inst`<=data, `inst_pc`<=pc, pc<=pc+4 (mod 2^32), `inst_valid`<=1, go to HOLD.
  - If `drop`=1: discard the data, clear `drop`, go to REQ.
- HOLD: `inst_valid`=1; outputs are stable until `inst_ready`. On handshake: `inst_valid`<=0, go to REQ.
- Decode fields are combinational slices of the `inst` register. They are valid whenever `inst_valid`=1.
- Redirect has priority over every other transition. In all cases pc<={redirect_pc[31:2],2'b00}.
  - REQ without handshake: stay in REQ; the new address appears next cycle.
  - REQ with handshake in the same cycle: go to WAIT with `drop`<=1.
  - WAIT: set `drop`<=1 and stay in WAIT. If the response arrives the same cycle, discard it and go to REQ.
  - HOLD: `inst_valid`<=0 next cycle and go to REQ. A coincident `inst_ready` handshake still counts as consumed, but the PC comes from the redirect.
- `imem_resp_valid` outside WAIT is a protocol violation and is ignored.
- Reset, any time including mid-fetch:
  - state=IDLE, pc=RESET_PC, `drop`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `imem_req_valid`=0.
  - A response arriving after reset is ignored (state is not WAIT).

## Timing
- Zero-wait memory (ready=1, response one cycle after handshake):
  - cycle n: REQ handshake;
  - n+1: WAIT, response captured;
  - n+2: HOLD, `inst_valid`=1;
  - with `inst_ready`=1 at n+2, the next REQ is at n+3.
- Throughput is 1 instruction per 3 cycles; each memory/decoder stall cycle adds one.
- First `imem_req_valid` is 1 cycle after `rst_n` deasserts; first `inst_valid` is at least 3 cycles after.
- Redirect to new-address request: 1 cycle from REQ or HOLD; from WAIT, 1 cycle after the stale response.
- No combinational path from `inst_ready` or `imem_resp_*` to any output. `imem_req_valid` and `inst_valid` are functions of state only.

## Test plan
- Reset, zero-wait memory returning `0x00000013` at every address.
  - Required: requests to 0x80000000, 0x80000004, 0x80000008 in order.
  - Required: `inst_valid` pulses at each word with the matching `inst_pc`, opcode=0x13, funct3=0, funct7=0.
- Backpressure: hold `inst_ready`=0 for 5 cycles with `inst`=0x40B50533 (sub).
  - Required: outputs stable, no new request issued.
  - Required: funct7=0x20, funct3=0, opcode=0x33.
- Redirect to 0x80000102 during WAIT, response 0xDEADBEEF arriving 2 cycles later.
  - Required: response dropped, no `inst_valid`.
  - Required: next request addr=0x80000100.
- Redirect in the same cycle as a REQ handshake.
  - Required: that response is dropped.
  - Required: next request goes to the redirect target.
- Redirect in HOLD coincident with `inst_ready`.
  - Required: the instruction is consumed once, `inst_valid` drops.
  - Required: next request addr equals the redirect target.
- PC wrap and reset.
  - Redirect to 0xFFFFFFFC and fetch: next request addr must be 0x00000000.
  - Assert `rst_n`=0 mid-WAIT: all outputs must return to reset values immediately; after release, fetch restarts at RESET_PC.
